// File: rtl/cu_ed_pkg.sv
// Shared types and sizing helpers for the energy-detection control unit.
// The optional short-burst flush is enabled by defining CU_ED_FLUSH_EN.
package cu_ed_pkg;

    typedef enum logic [2:0] {
        DET_CLR  = 3'd0,
        DET_IDLE = 3'd1,
        DET_ACC  = 3'd2,
        DET_SUB  = 3'd3,
        DET_DEC  = 3'd4,
        DET_PUSH = 3'd5
    } det_state_t;

    typedef enum logic {
        PK_WAIT  = 1'b0,
        PK_DRAIN = 1'b1
    } pack_state_t;

    localparam int WIN_LEN_DEF    = 64;
    localparam int PACK_LEN_DEF   = 32;
    localparam int FOUT_DEPTH_DEF = 64;

    localparam int WIN_W_DEF  = $clog2(WIN_LEN_DEF);
    localparam int BEAT_W_DEF = $clog2(PACK_LEN_DEF + 1);
    localparam int OCC_W_DEF  = $clog2(FOUT_DEPTH_DEF + 1);

    // Counter width able to hold values 0..n-1, never narrower than one bit.
    function automatic int cnt_w(input int n);
        if (n <= 2) begin
            return 1;
        end else begin
            return $clog2(n);
        end
    endfunction

endpackage

// File: rtl/cu_ed_pack_fsm.sv
// Packing sequencer: tracks output FIFO occupancy and drains framed bursts.
// With CU_ED_FLUSH_EN defined, a stop-terminated run flushes a short burst.
module cu_ed_pack_fsm
    import cu_ed_pkg::*;
#(
    parameter int PACK_LEN   = PACK_LEN_DEF,
    parameter int FOUT_DEPTH = FOUT_DEPTH_DEF
) (
    input  logic clock,
    input  logic reset,
    input  logic clr,
    input  logic push,
    input  logic out_ready,
    input  logic flush_req,
    input  logic run_start,
    output logic pop,
    output logic first,
    output logic last,
    output logic occ_nz,
    output logic draining
);

    localparam int OCC_W  = cnt_w(FOUT_DEPTH + 1);
    localparam int BEAT_W = cnt_w(PACK_LEN + 1);
    localparam logic [OCC_W-1:0]  OCC_BURST = OCC_W'(PACK_LEN);
    localparam logic [BEAT_W-1:0] BEAT_LOAD = BEAT_W'(PACK_LEN);
    localparam logic [BEAT_W-1:0] BEAT_ONE  = BEAT_W'(1);

    pack_state_t       state_r;
    pack_state_t       state_next_s;
    logic [OCC_W-1:0]  occ_r;
    logic [BEAT_W-1:0] beat_r;
    logic              first_r;
    logic              pop_s;
    logic              load_full_s;
    logic              load_occ_s;
    logic              flush_go_s;
    logic              flush_pend_r;

`ifdef CU_ED_FLUSH_EN
    assign flush_go_s = flush_pend_r && (occ_r != {OCC_W{1'b0}});
`else
    logic unused_flush_s;
    assign unused_flush_s = flush_req ^ run_start;
    assign flush_go_s     = 1'b0;
`endif

    assign pop_s    = (state_r == PK_DRAIN) && out_ready;
    assign pop      = pop_s;
    assign first    = pop_s && first_r;
    assign last     = pop_s && (beat_r == BEAT_ONE);
    assign occ_nz   = (occ_r != {OCC_W{1'b0}});
    assign draining = (state_r == PK_DRAIN);

    // Burst start decision and end-of-burst return to WAIT.
    always_comb begin
        state_next_s = state_r;
        load_full_s  = 1'b0;
        load_occ_s   = 1'b0;
        case (state_r)
            PK_WAIT: begin
                if (occ_r >= OCC_BURST) begin
                    state_next_s = PK_DRAIN;
                    load_full_s  = 1'b1;
                end else if (flush_go_s) begin
                    state_next_s = PK_DRAIN;
                    load_occ_s   = 1'b1;
                end else begin
                    state_next_s = PK_WAIT;
                end
            end
            PK_DRAIN: begin
                if (pop_s && (beat_r == BEAT_ONE)) begin
                    state_next_s = PK_WAIT;
                end else begin
                    state_next_s = PK_DRAIN;
                end
            end
            default: begin
                state_next_s = PK_WAIT;
            end
        endcase
    end

    // State, occupancy, beat and first-beat registers.
    always_ff @(posedge clock) begin
        if (!reset || clr) begin
            state_r <= PK_WAIT;
            occ_r   <= {OCC_W{1'b0}};
            beat_r  <= {BEAT_W{1'b0}};
            first_r <= 1'b0;
        end else begin
            state_r <= state_next_s;
            case ({push, pop_s})
                2'b10:   occ_r <= occ_r + OCC_W'(1);
                2'b01:   occ_r <= occ_r - OCC_W'(1);
                default: occ_r <= occ_r;
            endcase
            if (load_full_s) begin
                beat_r <= BEAT_LOAD;
            end else if (load_occ_s) begin
                beat_r <= BEAT_W'(occ_r);
            end else if (pop_s) begin
                beat_r <= beat_r - BEAT_ONE;
            end else begin
                beat_r <= beat_r;
            end
            if (load_full_s || load_occ_s) begin
                first_r <= 1'b1;
            end else if (pop_s) begin
                first_r <= 1'b0;
            end else begin
                first_r <= first_r;
            end
        end
    end

`ifdef CU_ED_FLUSH_EN
    // Pending short-burst request; survives a full burst so the remainder still drains.
    always_ff @(posedge clock) begin
        if (!reset || clr) begin
            flush_pend_r <= 1'b0;
        end else if (run_start) begin
            flush_pend_r <= 1'b0;
        end else if (flush_req) begin
            flush_pend_r <= 1'b1;
        end else if (load_occ_s || ((state_r == PK_WAIT) && !occ_nz)) begin
            flush_pend_r <= 1'b0;
        end else begin
            flush_pend_r <= flush_pend_r;
        end
    end
`else
    // Flush is compiled out; keep the register defined and idle.
    always_ff @(posedge clock) begin
        flush_pend_r <= 1'b0;
    end
`endif

endmodule

// File: rtl/control_unit_ed_param.sv
// Control unit for the energy-detection datapath: detection sequencer plus packer.
// Define CU_ED_FLUSH_EN to drain short bursts at the end of a stopped run.
module control_unit_ed_param
    import cu_ed_pkg::*;
#(
    parameter int WIN_LEN    = WIN_LEN_DEF,
    parameter int PACK_LEN   = PACK_LEN_DEF,
    parameter int FOUT_DEPTH = FOUT_DEPTH_DEF
) (
    input  logic clock,
    input  logic reset,
    input  logic start,
    input  logic stop,
    input  logic mode,
    input  logic empty_fin,
    input  logic out_ready,
    output logic pop_fin,
    output logic sclr_fin,
    output logic push_dl,
    output logic pop_dl,
    output logic sclr_dl,
    output logic sclr_ew,
    output logic ce_ew,
    output logic add_subn_ew,
    output logic sclr_dres,
    output logic en_dres,
    output logic end_sig,
    output logic push_fout,
    output logic pop_fout,
    output logic sclr_fout,
    output logic pack_first,
    output logic pack_last,
    output logic busy
);

    localparam int WIN_W = cnt_w(WIN_LEN);
    localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WIN_LEN - 1);

    det_state_t       state_r;
    det_state_t       state_next_s;
    logic             mode_r;
    logic             filled_r;
    logic             stop_seen_r;
    logic [WIN_W-1:0] win_cnt_r;
    logic             start_acc_s;
    logic             accept_s;
    logic             win_done_s;
    logic             flush_req_s;
    logic             clr_s;
    logic             occ_nz_s;
    logic             draining_s;

    assign clr_s = (state_r == DET_CLR);

    // Detection next-state and datapath strobes.
    always_comb begin
        state_next_s = state_r;
        start_acc_s  = 1'b0;
        accept_s     = 1'b0;
        win_done_s   = 1'b0;
        flush_req_s  = 1'b0;
        pop_fin      = 1'b0;
        sclr_fin     = 1'b0;
        push_dl      = 1'b0;
        pop_dl       = 1'b0;
        sclr_dl      = 1'b0;
        sclr_ew      = 1'b0;
        ce_ew        = 1'b0;
        add_subn_ew  = 1'b0;
        sclr_dres    = 1'b0;
        en_dres      = 1'b0;
        end_sig      = 1'b0;
        push_fout    = 1'b0;
        sclr_fout    = 1'b0;
        case (state_r)
            DET_CLR: begin
                sclr_fin     = 1'b1;
                sclr_dl      = 1'b1;
                sclr_ew      = 1'b1;
                sclr_dres    = 1'b1;
                sclr_fout    = 1'b1;
                state_next_s = DET_IDLE;
            end
            DET_IDLE: begin
                sclr_ew = 1'b1;
                sclr_dl = 1'b1;
                if (start) begin
                    start_acc_s  = 1'b1;
                    state_next_s = DET_ACC;
                end else begin
                    state_next_s = DET_IDLE;
                end
            end
            DET_ACC: begin
                accept_s    = !empty_fin;
                pop_fin     = accept_s;
                ce_ew       = accept_s;
                add_subn_ew = accept_s;
                push_dl     = accept_s && mode_r;
                win_done_s  = accept_s && !filled_r && (win_cnt_r == WIN_LAST);
                if (accept_s && filled_r) begin
                    state_next_s = DET_SUB;
                end else if (win_done_s) begin
                    state_next_s = DET_DEC;
                end else begin
                    state_next_s = DET_ACC;
                end
            end
            DET_SUB: begin
                pop_dl       = 1'b1;
                ce_ew        = 1'b1;
                state_next_s = DET_DEC;
            end
            DET_DEC: begin
                en_dres      = 1'b1;
                end_sig      = 1'b1;
                sclr_ew      = !mode_r;
                state_next_s = DET_PUSH;
            end
            DET_PUSH: begin
                push_fout = 1'b1;
                if (stop_seen_r || stop) begin
                    flush_req_s  = 1'b1;
                    state_next_s = DET_IDLE;
                end else begin
                    state_next_s = DET_ACC;
                end
            end
            default: begin
                state_next_s = DET_CLR;
            end
        endcase
    end

    // Detection state, latched mode, fill flag, stop memory and window counter.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_r     <= DET_CLR;
            mode_r      <= 1'b0;
            filled_r    <= 1'b0;
            stop_seen_r <= 1'b0;
            win_cnt_r   <= {WIN_W{1'b0}};
        end else begin
            state_r <= state_next_s;
            if (start_acc_s) begin
                mode_r    <= mode;
                filled_r  <= 1'b0;
                win_cnt_r <= {WIN_W{1'b0}};
            end else if (win_done_s) begin
                mode_r    <= mode_r;
                filled_r  <= mode_r;
                win_cnt_r <= {WIN_W{1'b0}};
            end else if (accept_s && !filled_r) begin
                mode_r    <= mode_r;
                filled_r  <= filled_r;
                win_cnt_r <= win_cnt_r + WIN_W'(1);
            end else begin
                mode_r    <= mode_r;
                filled_r  <= filled_r;
                win_cnt_r <= win_cnt_r;
            end
            // A stop is remembered until the next decision has been pushed.
            if ((state_r == DET_PUSH) || (state_r == DET_IDLE) || (state_r == DET_CLR)) begin
                stop_seen_r <= 1'b0;
            end else if (stop) begin
                stop_seen_r <= 1'b1;
            end else begin
                stop_seen_r <= stop_seen_r;
            end
        end
    end

    cu_ed_pack_fsm #(
        .PACK_LEN   (PACK_LEN),
        .FOUT_DEPTH (FOUT_DEPTH)
    ) u_pack (
        .clock     (clock),
        .reset     (reset),
        .clr       (clr_s),
        .push      (push_fout),
        .out_ready (out_ready),
        .flush_req (flush_req_s),
        .run_start (start_acc_s),
        .pop       (pop_fout),
        .first     (pack_first),
        .last      (pack_last),
        .occ_nz    (occ_nz_s),
        .draining  (draining_s)
    );

    assign busy = ((state_r != DET_IDLE) && (state_r != DET_CLR)) || occ_nz_s || draining_s;

endmodule

// File: tb/tb_control_unit_ed_param.sv
// Directed, table-driven bench for control_unit_ed_param with WIN_LEN=4, PACK_LEN=2.
// Expectations adapt to CU_ED_FLUSH_EN when the build defines it.
module tb_control_unit_ed_param;

    localparam logic [16:0] B_POP_FIN = 17'h10000;
    localparam logic [16:0] B_SC_FIN  = 17'h08000;
    localparam logic [16:0] B_PUSH_DL = 17'h04000;
    localparam logic [16:0] B_POP_DL  = 17'h02000;
    localparam logic [16:0] B_SC_DL   = 17'h01000;
    localparam logic [16:0] B_SC_EW   = 17'h00800;
    localparam logic [16:0] B_CE_EW   = 17'h00400;
    localparam logic [16:0] B_ADD     = 17'h00200;
    localparam logic [16:0] B_SC_DRES = 17'h00100;
    localparam logic [16:0] B_EN_DRES = 17'h00080;
    localparam logic [16:0] B_END     = 17'h00040;
    localparam logic [16:0] B_PUSH_FO = 17'h00020;
    localparam logic [16:0] B_POP_FO  = 17'h00010;
    localparam logic [16:0] B_SC_FO   = 17'h00008;
    localparam logic [16:0] B_FIRST   = 17'h00004;
    localparam logic [16:0] B_LAST    = 17'h00002;
    localparam logic [16:0] B_BUSY    = 17'h00001;

    localparam logic [16:0] O_CLR  = B_SC_FIN | B_SC_DL | B_SC_EW | B_SC_DRES | B_SC_FO;
    localparam logic [16:0] O_IDLE = B_SC_DL | B_SC_EW;
    localparam logic [16:0] O_ACC  = B_POP_FIN | B_CE_EW | B_ADD | B_BUSY;
    localparam logic [16:0] O_ACCS = O_ACC | B_PUSH_DL;
    localparam logic [16:0] O_SUB  = B_POP_DL | B_CE_EW | B_BUSY;
    localparam logic [16:0] O_DECB = B_EN_DRES | B_END | B_SC_EW | B_BUSY;
    localparam logic [16:0] O_DECS = B_EN_DRES | B_END | B_BUSY;
    localparam logic [16:0] O_PUSH = B_PUSH_FO | B_BUSY;
    localparam logic [16:0] P_F    = B_POP_FO | B_FIRST;
    localparam logic [16:0] P_L    = B_POP_FO | B_LAST;

`ifdef CU_ED_FLUSH_EN
    localparam logic FL = 1'b1;
`else
    localparam logic FL = 1'b0;
`endif

    typedef struct {
        logic        rst;
        logic        start;
        logic        stop;
        logic        mode;
        logic        empty;
        logic        ready;
        logic [16:0] exp;
    } vec_t;

    logic clock, reset, start, stop, mode, empty_fin, out_ready;
    logic pop_fin, sclr_fin, push_dl, pop_dl, sclr_dl, sclr_ew, ce_ew, add_subn_ew;
    logic sclr_dres, en_dres, end_sig, push_fout, pop_fout, sclr_fout;
    logic pack_first, pack_last, busy;
    logic [16:0] obs;

    int n_chk  = 0;
    int n_pass = 0;
    vec_t tbl[$];

    control_unit_ed_param #(
        .WIN_LEN    (4),
        .PACK_LEN   (2),
        .FOUT_DEPTH (8)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .start       (start),
        .stop        (stop),
        .mode        (mode),
        .empty_fin   (empty_fin),
        .out_ready   (out_ready),
        .pop_fin     (pop_fin),
        .sclr_fin    (sclr_fin),
        .push_dl     (push_dl),
        .pop_dl      (pop_dl),
        .sclr_dl     (sclr_dl),
        .sclr_ew     (sclr_ew),
        .ce_ew       (ce_ew),
        .add_subn_ew (add_subn_ew),
        .sclr_dres   (sclr_dres),
        .en_dres     (en_dres),
        .end_sig     (end_sig),
        .push_fout   (push_fout),
        .pop_fout    (pop_fout),
        .sclr_fout   (sclr_fout),
        .pack_first  (pack_first),
        .pack_last   (pack_last),
        .busy        (busy)
    );

    assign obs = {pop_fin, sclr_fin, push_dl, pop_dl, sclr_dl, sclr_ew, ce_ew, add_subn_ew,
                  sclr_dres, en_dres, end_sig, push_fout, pop_fout, sclr_fout,
                  pack_first, pack_last, busy};

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic check(input string name, input logic [16:0] act, input logic [16:0] exp);
        n_chk++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %05h expected %05h", name, act, exp);
        end
    endtask

    task automatic row(input logic r, input logic s, input logic p, input logic m,
                       input logic e, input logic y, input logic [16:0] x);
        vec_t v;
        v.rst = r; v.start = s; v.stop = p; v.mode = m; v.empty = e; v.ready = y; v.exp = x;
        tbl.push_back(v);
    endtask

    initial begin
        reset = 1'b0; start = 1'b0; stop = 1'b0; mode = 1'b0;
        empty_fin = 1'b0; out_ready = 1'b1;

        // Block mode: three windows, two-beat burst, stop, then tail handling.
        row(0, 0, 0, 0, 0, 1, O_CLR);
        row(1, 0, 0, 0, 0, 1, O_CLR);
        row(1, 1, 0, 0, 0, 1, O_IDLE);
        for (int i = 0; i < 4; i++) row(1, 0, 0, 0, 0, 1, O_ACC);
        row(1, 0, 0, 0, 0, 1, O_DECB);
        row(1, 0, 0, 0, 0, 1, O_PUSH);
        for (int i = 0; i < 4; i++) row(1, 0, 0, 0, 0, 1, O_ACC);
        row(1, 0, 0, 0, 0, 1, O_DECB);
        row(1, 0, 0, 0, 0, 1, O_PUSH);
        row(1, 0, 1, 0, 0, 1, O_ACC);
        row(1, 0, 0, 0, 0, 1, O_ACC | P_F);
        row(1, 0, 0, 0, 0, 1, O_ACC | P_L);
        row(1, 0, 0, 0, 0, 1, O_ACC);
        row(1, 0, 0, 0, 0, 1, O_DECB);
        row(1, 0, 0, 0, 0, 1, O_PUSH);
        row(1, 0, 0, 0, 0, 1, O_IDLE | B_BUSY);
        row(1, 0, 0, 0, 0, 1, FL ? (O_IDLE | P_F | P_L | B_BUSY) : (O_IDLE | B_BUSY));
        row(1, 0, 0, 0, 0, 1, FL ? O_IDLE : (O_IDLE | B_BUSY));
        // Reset, then sliding mode (mode only presented on the start cycle).
        row(0, 0, 0, 0, 0, 1, FL ? O_IDLE : (O_IDLE | B_BUSY));
        row(1, 0, 0, 0, 0, 1, O_CLR);
        row(1, 1, 0, 1, 0, 1, O_IDLE);
        for (int i = 0; i < 4; i++) row(1, 0, 0, 0, 0, 1, O_ACCS);
        row(1, 0, 0, 0, 0, 1, O_DECS);
        row(1, 0, 0, 0, 0, 1, O_PUSH);
        row(1, 0, 0, 0, 0, 1, O_ACCS);
        row(1, 0, 0, 0, 0, 1, O_SUB);
        row(1, 0, 0, 0, 0, 1, O_DECS);
        row(1, 0, 0, 0, 0, 1, O_PUSH);
        row(1, 0, 0, 0, 0, 1, O_ACCS);
        row(1, 0, 0, 0, 0, 1, O_SUB | P_F);
        row(1, 0, 0, 0, 0, 1, O_DECS | P_L);
        row(1, 0, 0, 0, 0, 1, O_PUSH);
        // Reset pulled low during ACC aborts the run.
        row(0, 0, 0, 0, 0, 1, O_ACCS);
        row(1, 0, 0, 0, 0, 1, O_CLR);
        row(1, 0, 0, 0, 0, 1, O_IDLE);
        row(1, 0, 0, 0, 0, 1, O_IDLE);

        @(negedge clock);
        @(negedge clock);
        for (int i = 0; i < tbl.size(); i++) begin
            @(negedge clock);
            reset = tbl[i].rst; start = tbl[i].start; stop = tbl[i].stop;
            mode = tbl[i].mode; empty_fin = tbl[i].empty; out_ready = tbl[i].ready;
            #1;
            check($sformatf("row%0d", i), obs, tbl[i].exp);
        end

        // Input FIFO empty for three ACC cycles delays the decision by three cycles.
        for (int c = 0; c <= 12; c++) begin
            @(negedge clock);
            reset = 1'b1; mode = 1'b0; out_ready = 1'b1;
            start = (c == 0); stop = (c == 1); empty_fin = (c >= 3 && c <= 5);
            #1;
            check($sformatf("stall_pop_fin_c%0d", c), 17'(pop_fin), 17'(c == 1 || c == 2 || c == 6 || c == 7));
            check($sformatf("stall_ce_ew_c%0d", c), 17'(ce_ew), 17'(c == 1 || c == 2 || c == 6 || c == 7));
            check($sformatf("stall_end_sig_c%0d", c), 17'(end_sig), 17'(c == 8));
            check($sformatf("stall_pop_fout_c%0d", c), 17'(pop_fout), 17'(FL && c == 11));
            if (c == 12) check("stall_busy_tail", 17'(busy), 17'(!FL));
        end

        @(negedge clock);
        reset = 1'b0; stop = 1'b0; start = 1'b0; empty_fin = 1'b0;
        @(negedge clock);
        #1;
        check("reset_clr", obs, O_CLR);
        @(negedge clock);
        reset = 1'b1;

        // out_ready low for five cycles in the middle of a burst, with a push during the stall.
        for (int c = 0; c <= 33; c++) begin
            @(negedge clock);
            mode = 1'b0; empty_fin = 1'b0;
            start = (c == 0); stop = (c == 27); out_ready = !(c >= 15 && c <= 19);
            #1;
            check($sformatf("bp_pop_c%0d", c), 17'(pop_fout),
                  17'(c == 14 || c == 20 || c == 26 || c == 27 || (FL && c == 32)));
            check($sformatf("bp_first_c%0d", c), 17'(pack_first), 17'(c == 14 || c == 26 || (FL && c == 32)));
            check($sformatf("bp_last_c%0d", c), 17'(pack_last), 17'(c == 20 || c == 27 || (FL && c == 32)));
            check($sformatf("bp_push_c%0d", c), 17'(push_fout),
                  17'(c == 6 || c == 12 || c == 18 || c == 24 || c == 30));
            if (c == 33) check("bp_busy_tail", 17'(busy), 17'(!FL));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
